// File: rtl/convolve_line_seq.sv
// rtl/convolve_line_seq.sv - time-multiplexed signed line convolution engine with saturating accumulate
module convolve_line_seq #(
    parameter int DATA_W = 16,
    parameter int TAPS   = 64,
    parameter int LANES  = 8,
    parameter int ACC_W  = 48
) (
    input  logic                     clk_in,
    input  logic                     rst_n_in,
    input  logic [TAPS*DATA_W-1:0]   ir_line_in,
    input  logic [TAPS*DATA_W-1:0]   audio_line_in,
    input  logic                     first_in,
    input  logic                     last_in,
    input  logic                     valid_in,
    output logic                     ready_out,
    output logic [ACC_W-1:0]         result_out,
    output logic                     result_valid_out,
    input  logic                     result_ready_in,
    output logic                     overflow_out
);

    localparam int BEATS  = TAPS / LANES;
    localparam int BW     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int EXT_W  = ACC_W + $clog2(LANES) + 1;
    localparam int LINE_W = TAPS * DATA_W;
    localparam int STEP_W = LANES * DATA_W;

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_t;

    state_t              r_state;
    logic [LINE_W-1:0]   r_ir;
    logic [LINE_W-1:0]   r_audio;
    logic                r_last;
    logic [BW-1:0]       r_beat;
    logic [ACC_W-1:0]    r_acc;
    logic                r_ovf;
    logic [ACC_W-1:0]    r_result;
    logic                r_result_ovf;
    logic                r_result_valid;

    logic [EXT_W-1:0]    w_prod_ext [LANES];
    logic [EXT_W-1:0]    w_lane_sum;
    logic [EXT_W-1:0]    w_sum;
    logic                w_clamp;
    logic [ACC_W-1:0]    w_sat;

    // Lanes always read the bottom IR slice and the top audio slice; the
    // lines shift each beat so the reversed pairing walks across the taps.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [DATA_W-1:0]   w_c;
        logic [DATA_W-1:0]   w_s;
        logic [2*DATA_W-1:0] w_p;
        assign w_c = r_ir[l*DATA_W +: DATA_W];
        assign w_s = r_audio[(TAPS-1-l)*DATA_W +: DATA_W];
        assign w_p = {{DATA_W{w_c[DATA_W-1]}}, w_c} * {{DATA_W{w_s[DATA_W-1]}}, w_s};
        assign w_prod_ext[l] = {{(EXT_W-2*DATA_W){w_p[2*DATA_W-1]}}, w_p};
    end

    always_comb begin
        w_lane_sum = '0;
        for (int l = 0; l < LANES; l++) begin
            w_lane_sum = w_lane_sum + w_prod_ext[l];
        end
        w_sum   = {{(EXT_W-ACC_W){r_acc[ACC_W-1]}}, r_acc} + w_lane_sum;
        // Upper bits must all equal the ACC_W sign bit, otherwise it does not fit.
        w_clamp = ~(&w_sum[EXT_W-1:ACC_W-1]) & (|w_sum[EXT_W-1:ACC_W-1]);
        if (!w_clamp) begin
            w_sat = w_sum[ACC_W-1:0];
        end else if (w_sum[EXT_W-1]) begin
            w_sat = {1'b1, {(ACC_W-1){1'b0}}};
        end else begin
            w_sat = {1'b0, {(ACC_W-1){1'b1}}};
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state        <= S_IDLE;
            r_ir           <= '0;
            r_audio        <= '0;
            r_last         <= 1'b0;
            r_beat         <= '0;
            r_acc          <= '0;
            r_ovf          <= 1'b0;
            r_result       <= '0;
            r_result_ovf   <= 1'b0;
            r_result_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (valid_in) begin
                        r_ir    <= ir_line_in;
                        r_audio <= audio_line_in;
                        r_last  <= last_in;
                        r_beat  <= '0;
                        if (first_in) begin
                            r_acc <= '0;
                            r_ovf <= 1'b0;
                        end
                        r_state <= S_MAC;
                    end
                end
                S_MAC: begin
                    r_acc   <= w_sat;
                    r_ovf   <= r_ovf | w_clamp;
                    r_ir    <= r_ir >> STEP_W;
                    r_audio <= r_audio << STEP_W;
                    r_beat  <= r_beat + BW'(1);
                    if (r_beat == BW'(BEATS-1)) begin
                        if (r_last) begin
                            r_result       <= w_sat;
                            r_result_ovf   <= r_ovf | w_clamp;
                            r_result_valid <= 1'b1;
                            r_state        <= S_OUT;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_OUT: begin
                    if (result_ready_in) begin
                        r_result_valid <= 1'b0;
                        r_state        <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Gated by reset so the port reads 0 while held in reset and 1 the moment it releases.
    assign ready_out        = rst_n_in & (r_state == S_IDLE);
    assign result_out       = r_result;
    assign result_valid_out = r_result_valid;
    assign overflow_out     = r_result_ovf;

endmodule

// File: tb/tb_convolve_line_seq.sv
// tb/tb_convolve_line_seq.sv - directed self-checking bench for convolve_line_seq
module tb_convolve_line_seq;

    localparam int DW     = 16;
    localparam int TAPS   = 64;
    localparam int LINE_W = TAPS * DW;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [LINE_W-1:0] ir_line;
    logic [LINE_W-1:0] audio_line;
    logic              first, last;
    logic              valid0, valid1, rready0, rready1;
    logic              ready0, rvalid0, ovf0;
    logic              ready1, rvalid1, ovf1;
    logic [47:0]       res0;
    logic [31:0]       res1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    convolve_line_seq u_dut (
        .clk_in(clk), .rst_n_in(rst_n), .ir_line_in(ir_line), .audio_line_in(audio_line),
        .first_in(first), .last_in(last), .valid_in(valid0), .ready_out(ready0),
        .result_out(res0), .result_valid_out(rvalid0), .result_ready_in(rready0),
        .overflow_out(ovf0)
    );

    convolve_line_seq #(.ACC_W(32)) u_dut32 (
        .clk_in(clk), .rst_n_in(rst_n), .ir_line_in(ir_line), .audio_line_in(audio_line),
        .first_in(first), .last_in(last), .valid_in(valid1), .ready_out(ready1),
        .result_out(res1), .result_valid_out(rvalid1), .result_ready_in(rready1),
        .overflow_out(ovf1)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_all(input logic [15:0] iv, input logic [15:0] av);
        for (int i = 0; i < TAPS; i++) begin
            ir_line[i*DW +: DW]    = iv;
            audio_line[i*DW +: DW] = av;
        end
    endtask

    task automatic accept(input bit sel, input bit f, input bit l);
        bit rdy;
        rdy = 1'b0;
        for (int c = 0; c < 40 && !rdy; c++) begin
            @(negedge clk);
            rdy = sel ? ready1 : ready0;
        end
        if (!rdy) check("accept_timeout", 64'd0, 64'd1);
        first = f;
        last  = l;
        if (sel) valid1 = 1'b1; else valid0 = 1'b1;
        @(posedge clk);
        #1;
        valid0 = 1'b0;
        valid1 = 1'b0;
    endtask

    task automatic wait_result(input bit sel, output int n, output bit ready_low);
        n = 0;
        ready_low = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (sel ? rvalid1 : rvalid0) begin
                n = c;
                break;
            end
            if (sel ? ready1 : ready0) ready_low = 1'b0;
        end
    endtask

    int n;
    bit rl;
    int c_ready;
    bit seen;

    initial begin
        rst_n = 1'b0; valid0 = 1'b0; valid1 = 1'b0; rready0 = 1'b1; rready1 = 1'b1;
        first = 1'b0; last = 1'b0; ir_line = '0; audio_line = '0;
        repeat (3) @(negedge clk);
        check("rst_result", 64'(res0), 64'd0);
        check("rst_valid", 64'(rvalid0), 64'd0);
        check("rst_ovf", 64'(ovf0), 64'd0);
        rst_n = 1'b1;
        #1;
        check("rst_ready_after", 64'(ready0), 64'd1);

        // 1: all ones single line
        set_all(16'd1, 16'd1);
        accept(1'b0, 1'b1, 1'b1);
        wait_result(1'b0, n, rl);
        check("t1_latency", 64'(n), 64'd8);
        check("t1_ready_low", 64'(rl), 64'd1);
        check("t1_result", 64'(res0), 64'd64);
        check("t1_ovf", 64'(ovf0), 64'd0);

        // 2: sign and reversed indexing
        set_all(16'd0, 16'd0);
        ir_line[0 +: DW] = 16'hFFFD;
        audio_line[63*DW +: DW] = 16'd7;
        accept(1'b0, 1'b1, 1'b1);
        wait_result(1'b0, n, rl);
        check("t2_result_neg", 64'(res0), 64'h0000_FFFF_FFFF_FFEB);
        audio_line[63*DW +: DW] = 16'd0;
        audio_line[0 +: DW] = 16'd7;
        accept(1'b0, 1'b1, 1'b1);
        wait_result(1'b0, n, rl);
        check("t2_result_zero", 64'(res0), 64'd0);

        // 3: multi-segment accumulation
        set_all(16'd1, 16'd2);
        accept(1'b0, 1'b1, 1'b0);
        c_ready = 0;
        seen = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (rvalid0) seen = 1'b1;
            if (ready0 && c_ready == 0) c_ready = c;
        end
        check("t3_ready_back", 64'(c_ready), 64'd8);
        check("t3_no_valid", 64'(seen), 64'd0);
        set_all(16'd1, 16'd1);
        accept(1'b0, 1'b0, 1'b1);
        wait_result(1'b0, n, rl);
        check("t3_result_sum", 64'(res0), 64'd192);
        accept(1'b0, 1'b1, 1'b1);
        wait_result(1'b0, n, rl);
        check("t3_result_clear", 64'(res0), 64'd64);

        // 4: saturation on the 32-bit instance
        set_all(16'h7FFF, 16'h7FFF);
        accept(1'b1, 1'b1, 1'b1);
        wait_result(1'b1, n, rl);
        check("t4_pos_latency", 64'(n), 64'd8);
        check("t4_pos_result", 64'(res1), 64'h7FFF_FFFF);
        check("t4_pos_ovf", 64'(ovf1), 64'd1);
        set_all(16'h8000, 16'h7FFF);
        accept(1'b1, 1'b1, 1'b1);
        wait_result(1'b1, n, rl);
        check("t4_neg_result", 64'(res1), 64'h8000_0000);
        check("t4_neg_ovf", 64'(ovf1), 64'd1);
        set_all(16'd1, 16'd1);
        accept(1'b1, 1'b1, 1'b1);
        wait_result(1'b1, n, rl);
        check("t4_clear_result", 64'(res1), 64'd64);
        check("t4_clear_ovf", 64'(ovf1), 64'd0);

        // 5: output backpressure, concurrent input ignored
        rready0 = 1'b0;
        set_all(16'd1, 16'd1);
        accept(1'b0, 1'b1, 1'b1);
        wait_result(1'b0, n, rl);
        check("t5_latency", 64'(n), 64'd8);
        set_all(16'd2, 16'd2);
        first = 1'b1; last = 1'b1; valid0 = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("t5_hold_result", 64'(res0), 64'd64);
            check("t5_hold_valid", 64'(rvalid0), 64'd1);
            check("t5_hold_ready", 64'(ready0), 64'd0);
        end
        valid0 = 1'b0;
        rready0 = 1'b1;
        @(negedge clk);
        check("t5_valid_drop", 64'(rvalid0), 64'd0);
        check("t5_ready_back", 64'(ready0), 64'd1);
        seen = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (rvalid0) seen = 1'b1;
        end
        check("t5_ignored_input", 64'(seen), 64'd0);

        // 6: reset mid-computation
        set_all(16'd1, 16'd1);
        accept(1'b0, 1'b1, 1'b1);
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        check("t6_rst_result", 64'(res0), 64'd0);
        check("t6_rst_valid", 64'(rvalid0), 64'd0);
        check("t6_rst_ovf", 64'(ovf0), 64'd0);
        check("t6_rst_ready", 64'(ready0), 64'd0);
        check("t6_rst_result32", 64'(res1), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("t6_ready_release", 64'(ready0), 64'd1);
        seen = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (rvalid0) seen = 1'b1;
        end
        check("t6_no_emit", 64'(seen), 64'd0);
        accept(1'b0, 1'b1, 1'b1);
        wait_result(1'b0, n, rl);
        check("t6_after_latency", 64'(n), 64'd8);
        check("t6_after_result", 64'(res0), 64'd64);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
